// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes,
// datapath select codes, state encoding and the control-word struct.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ      = 4'd9,
    S_BNE      = 4'd10,
    S_JUMP     = 4'd11,
    S_IMM_EX   = 4'd12,
    S_IMM_WB   = 4'd13
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond_beq;
    logic       pcwritecond_bne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI) || (op == OP_ANDI);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory-ready in, control strobes out.
// master = controller, slave = datapath.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond_beq;
  logic       pcwritecond_bne;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic       illegal_op;

  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond_beq, pcwritecond_bne, iord, memread, memwrite,
           irwrite, memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond_beq, pcwritecond_bne, iord, memread, memwrite,
           irwrite, memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           illegal_op
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode of the FSM state.
// Ports: state, op (used in DECODE/IMM_EX), mem_ready (gates FETCH writes) -> ctrl.
module mc_ctrl_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = ALUSRCB_FOUR;
        // IR/PC only advance once the instruction word has actually arrived
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb    = ALUSRCB_IMMSH;
        ctrl.illegal_op = !op_legal(op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ctrl.alusrca         = 1'b1;
        ctrl.aluop           = ALUOP_SUB;
        ctrl.pcsource        = PCSRC_ALUOUT;
        ctrl.pcwritecond_beq = (state == S_BEQ);
        ctrl.pcwritecond_bne = (state == S_BNE);
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      S_IMM_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = (op == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_IMM_WB: ctrl.regwrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic,
// retired-instruction counter; control word decoded by mc_ctrl_decode.
// Ports: clk, rst_n (async low), bus (op/mem_ready in, controls out),
//        state (debug), instr_count (retired instructions, wraps).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus,
  output logic [3:0]           state,
  output logic [CNT_W-1:0]     instr_count
);

  state_t state_q, state_nxt;
  ctrl_t  ctrl;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_RST:      state_nxt = S_FETCH;
      S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (bus.op)
          OP_LW, OP_SW:     state_nxt = S_MEMADR;
          OP_RTYPE:         state_nxt = S_RTYPE_EX;
          OP_BEQ:           state_nxt = S_BEQ;
          OP_BNE:           state_nxt = S_BNE;
          OP_J:             state_nxt = S_JUMP;
          OP_ADDI, OP_ANDI: state_nxt = S_IMM_EX;
          default:          state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (bus.mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWR:    if (bus.mem_ready) state_nxt = S_FETCH;
      S_RTYPE_EX: state_nxt = S_RTYPE_WB;
      S_RTYPE_WB: state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_BNE:      state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_IMM_EX:   state_nxt = S_IMM_WB;
      S_IMM_WB:   state_nxt = S_FETCH;
      default:    state_nxt = S_RST;
    endcase
  end

  // Only completing states retire; an illegal op returns from DECODE uncounted.
  always_comb begin
    unique case (state_q)
      S_MEMWB, S_RTYPE_WB, S_BEQ, S_BNE, S_JUMP, S_IMM_WB: retire = 1'b1;
      S_MEMWR: retire = bus.mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + 1'b1;
  end

  mc_ctrl_decode u_dec (
    .state     (state_q),
    .op        (bus.op),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign state               = state_q;
  assign bus.pcwrite         = ctrl.pcwrite;
  assign bus.pcwritecond_beq = ctrl.pcwritecond_beq;
  assign bus.pcwritecond_bne = ctrl.pcwritecond_bne;
  assign bus.iord            = ctrl.iord;
  assign bus.memread         = ctrl.memread;
  assign bus.memwrite        = ctrl.memwrite;
  assign bus.irwrite         = ctrl.irwrite;
  assign bus.memtoreg        = ctrl.memtoreg;
  assign bus.regdst          = ctrl.regdst;
  assign bus.regwrite        = ctrl.regwrite;
  assign bus.alusrca         = ctrl.alusrca;
  assign bus.alusrcb         = ctrl.alusrcb;
  assign bus.aluop           = ctrl.aluop;
  assign bus.pcsource        = ctrl.pcsource;
  assign bus.illegal_op      = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through the FSM and checks state, strobes and retire count.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  state;
  logic [31:0] instr_count;
  int          n_chk = 0;
  int          n_err = 0;

  multicycle_control_if bus ();

  multicycle_control #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock, sample 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.op        = 6'b100011;
    bus.mem_ready = 1'b1;
    #12;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_memread", {31'd0, bus.memread}, 32'd0);
    chk("rst_pcwrite", {31'd0, bus.pcwrite}, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_state", {28'd0, state}, 32'd0);

    // lw: 1,2,3,4,5,1
    cyc(); chk("lw_fetch", {28'd0, state}, 32'd1);
    chk("lw_f_irwrite", {31'd0, bus.irwrite}, 32'd1);
    chk("lw_f_pcwrite", {31'd0, bus.pcwrite}, 32'd1);
    chk("lw_f_alusrcb", {30'd0, bus.alusrcb}, 32'd1);
    cyc(); chk("lw_decode", {28'd0, state}, 32'd2);
    chk("lw_d_alusrcb", {30'd0, bus.alusrcb}, 32'd3);
    cyc(); chk("lw_memadr", {28'd0, state}, 32'd3);
    chk("lw_a_srca_srcb", {29'd0, bus.alusrca, bus.alusrcb}, 32'b110);
    cyc(); chk("lw_memrd", {28'd0, state}, 32'd4);
    chk("lw_r_iord_rd", {30'd0, bus.iord, bus.memread}, 32'b11);
    cyc(); chk("lw_memwb", {28'd0, state}, 32'd5);
    chk("lw_wb_regw_m2r", {30'd0, bus.regwrite, bus.memtoreg}, 32'b11);
    cyc(); chk("lw_done", {28'd0, state}, 32'd1);
    chk("lw_count", instr_count, 32'd1);

    // FETCH stall, then illegal op
    bus.mem_ready = 1'b0; #1;
    chk("stall_irwrite", {31'd0, bus.irwrite}, 32'd0);
    chk("stall_pcwrite", {31'd0, bus.pcwrite}, 32'd0);
    chk("stall_memread", {31'd0, bus.memread}, 32'd1);
    cyc(); chk("stall_hold", {28'd0, state}, 32'd1);
    bus.mem_ready = 1'b1;
    bus.op = 6'b111111;
    cyc(); chk("ill_decode", {28'd0, state}, 32'd2);
    chk("ill_flag", {31'd0, bus.illegal_op}, 32'd1);
    cyc(); chk("ill_fetch", {28'd0, state}, 32'd1);
    chk("ill_count", instr_count, 32'd1);
    chk("ill_flag_clr", {31'd0, bus.illegal_op}, 32'd0);

    // andi
    bus.op = 6'b001100;
    cyc(); chk("andi_decode_legal", {31'd0, bus.illegal_op}, 32'd0);
    cyc(); chk("andi_ex", {28'd0, state}, 32'd12);
    chk("andi_aluop", {30'd0, bus.aluop}, 32'd3);
    chk("andi_alusrcb", {30'd0, bus.alusrcb}, 32'd2);
    cyc(); chk("andi_wb", {28'd0, state}, 32'd13);
    chk("andi_wb_regdst_regw", {30'd0, bus.regdst, bus.regwrite}, 32'b01);
    cyc(); chk("andi_count", instr_count, 32'd2);

    // addi
    bus.op = 6'b001000;
    cyc(); cyc(); chk("addi_ex", {28'd0, state}, 32'd12);
    chk("addi_aluop", {30'd0, bus.aluop}, 32'd0);
    chk("addi_srca", {31'd0, bus.alusrca}, 32'd1);
    cyc(); chk("addi_wb_regdst", {31'd0, bus.regdst}, 32'd0);
    cyc(); chk("addi_count", instr_count, 32'd3);

    // beq then bne
    bus.op = 6'b000100;
    cyc(); cyc(); chk("beq_state", {28'd0, state}, 32'd9);
    chk("beq_conds", {30'd0, bus.pcwritecond_beq, bus.pcwritecond_bne}, 32'b10);
    chk("beq_aluop", {30'd0, bus.aluop}, 32'd1);
    chk("beq_pcsrc", {30'd0, bus.pcsource}, 32'd1);
    cyc(); chk("beq_fetch", {28'd0, state}, 32'd1);
    chk("beq_cond_clr", {31'd0, bus.pcwritecond_beq}, 32'd0);
    chk("beq_count", instr_count, 32'd4);
    bus.op = 6'b000101;
    cyc(); cyc(); chk("bne_state", {28'd0, state}, 32'd10);
    chk("bne_conds", {30'd0, bus.pcwritecond_beq, bus.pcwritecond_bne}, 32'b01);
    chk("bne_aluop_pcsrc", {28'd0, bus.aluop, bus.pcsource}, 32'b0101);
    cyc(); chk("bne_count", instr_count, 32'd5);

    // R-type
    bus.op = 6'b000000;
    cyc(); cyc(); chk("r_ex", {28'd0, state}, 32'd7);
    chk("r_aluop", {30'd0, bus.aluop}, 32'd2);
    cyc(); chk("r_wb", {28'd0, state}, 32'd8);
    chk("r_wb_regdst_regw", {30'd0, bus.regdst, bus.regwrite}, 32'b11);
    cyc(); chk("r_count", instr_count, 32'd6);

    // jump
    bus.op = 6'b000010;
    cyc(); cyc(); chk("j_state", {28'd0, state}, 32'd11);
    chk("j_pcwrite", {31'd0, bus.pcwrite}, 32'd1);
    chk("j_pcsrc", {30'd0, bus.pcsource}, 32'd2);
    cyc(); chk("j_count", instr_count, 32'd7);

    // sw with three stall cycles in MEMWR
    bus.op = 6'b101011;
    cyc(); cyc(); chk("sw_memadr", {28'd0, state}, 32'd3);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("sw_wait_state", {28'd0, state}, 32'd6);
      chk("sw_wait_memwrite", {31'd0, bus.memwrite}, 32'd1);
      chk("sw_wait_count", instr_count, 32'd7);
    end
    bus.mem_ready = 1'b1; #1;
    chk("sw_last_memwrite", {30'd0, bus.iord, bus.memwrite}, 32'b11);
    cyc(); chk("sw_fetch", {28'd0, state}, 32'd1);
    chk("sw_memwrite_clr", {31'd0, bus.memwrite}, 32'd0);
    chk("sw_count", instr_count, 32'd8);

    // reset mid-MEMWR
    cyc(); cyc(); bus.mem_ready = 1'b0;
    cyc(); chk("rmid_memwr", {28'd0, state}, 32'd6);
    chk("rmid_memwrite", {31'd0, bus.memwrite}, 32'd1);
    #1 rst_n = 1'b0; #1;
    chk("rmid_state", {28'd0, state}, 32'd0);
    chk("rmid_memwrite_off", {31'd0, bus.memwrite}, 32'd0);
    chk("rmid_count", instr_count, 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    cyc(); chk("rmid_fetch", {28'd0, state}, 32'd1);
    chk("rmid_count_after", instr_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
